sc_scbc_gsr_mc: RTL

//  Parametrised successor of the SCBC general status/control register block.
//  - Holds the version register, ULPI PHY control with a timed auto-reset sequencer,
//    and an NUM_IRQ-channel interrupt controller: sticky W1C status, enable and mode registers.
//  - Sits on the SCBC register bus. Drives the single system INTERRUPT line.

---
 rtl/sc_scbc_gsr_mc_pkg.sv | 55 +++++
 rtl/sc_scbc_gsr_mc_sync.sv | 27 ++
 rtl/sc_scbc_gsr_mc.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sc_scbc_gsr_mc_pkg.sv
// Shared SCBC register-bus definitions: offsets, reset values, field layouts
// and the decode/byte-enable write helpers used by the status/control blocks.
package sc_scbc_reg_pkg;

    localparam logic [7:0] scbcVER_p  = 8'h00;
    localparam logic [7:0] scbcUPC2_p = 8'h04;
    localparam logic [7:0] scbcISR2_p = 8'h08;
    localparam logic [7:0] scbcIER2_p = 8'h0C;
    localparam logic [7:0] scbcIMR_p  = 8'h10;

    localparam logic [31:0] scbcVER_init  = 32'h0002_0100;
    localparam logic [31:0] scbcUPC2_init = '0;
    localparam logic [31:0] scbcISR2_init = '0;
    localparam logic [31:0] scbcIER2_init = '0;
    localparam logic [31:0] scbcIMR_init  = '0;

    localparam logic [31:0] scbcISR2_w1c_mask = 32'hFFFF_FFFF;
    localparam logic [31:0] scbcUPC2_ro_mask  = 32'h0000_0104;

    typedef struct packed {
        logic [22:0] rsvd1;
        logic        ulpi_clk_st;
        logic [4:0]  rsvd0;
        logic        rst_pulse;
        logic        ulpi_power_down;
        logic        ulpi_reset;
    } scbcUPC2_t;

    typedef struct packed {
        logic        phy_timeout;
        logic [30:0] src;
    } scbcIrq_t;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_CLK
    } scbcRstSeq_e;

    function automatic logic isRegHit(input logic [63:0] adr, input logic [7:0] offset);
        return adr == {56'd0, offset};
    endfunction

    // Merge write data into the current value, one byte lane per enable bit.
    function automatic logic [31:0] scRegWr(input logic [31:0] cur, input logic [31:0] wdat,
                                            input logic [3:0] ben);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (ben[b]) m[b*8 +: 8] = 8'hFF;
        end
        return (cur & ~m) | (wdat & m);
    endfunction

endpackage

// File: rtl/sc_scbc_gsr_mc_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous status inputs.
module sc_scbc_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sc_scbc_gsr_mc.sv
// SCBC general status/control block: version, ULPI PHY control with timed
// auto-reset sequencer, and an interrupt controller with sticky/level status.
module sc_scbc_gsr_mc
    import sc_scbc_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned NUM_IRQ          = 8,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned RST_PULSE_CYCLES = 64,
    parameter int unsigned CLK_TIMEOUT      = 4096
) (
    input  logic                  SYSCLK,
    input  logic                  SYSRST,
    output logic                  INTERRUPT,
    input  logic                  WENB,
    input  logic [ADDR_WIDTH-1:0] WADR,
    input  logic [31:0]           WDAT,
    input  logic [3:0]            WBEN,
    input  logic                  RENB,
    input  logic [ADDR_WIDTH-1:0] RADR,
    output logic [31:0]           RDAT,
    input  logic [NUM_IRQ-1:0]    IRQ_SRC,
    output logic                  ULPI_PWRDWNB,
    output logic                  ULPI_RSTB,
    input  logic                  ULPI_CLKSTATE
);

    localparam int unsigned CNT_MAX = (RST_PULSE_CYCLES > CLK_TIMEOUT) ? RST_PULSE_CYCLES : CLK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(CLK_TIMEOUT - 1);
    localparam logic [31:0] SRC_MASK = (32'd1 << NUM_IRQ) - 32'd1;
    localparam logic [31:0] IRQ_MASK = SRC_MASK | 32'h8000_0000;

    logic [NUM_IRQ-1:0] irq_sync, irq_prev;
    logic               clk_sync;
    logic               ulpi_reset, ulpi_pwrdn;
    logic [31:0]        isr, ier, imr, isr_next;
    logic [31:0]        set_vec, edge_mask, w1c, rd_val;
    logic               irq_out;
    logic [31:0]        rdat;
    scbcUPC2_t          upc_rd;
    scbcRstSeq_e        state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               seq_start, seq_timeout;
    logic               wr_upc, wr_isr, wr_ier, wr_imr;

    sc_scbc_sync #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_irq_sync (
        .clk(SYSCLK), .rst(SYSRST), .d(IRQ_SRC), .q(irq_sync)
    );

    sc_scbc_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_clk_sync (
        .clk(SYSCLK), .rst(SYSRST), .d(ULPI_CLKSTATE), .q(clk_sync)
    );

    assign wr_upc    = WENB && isRegHit(64'(WADR), scbcUPC2_p);
    assign wr_isr    = WENB && isRegHit(64'(WADR), scbcISR2_p);
    assign wr_ier    = WENB && isRegHit(64'(WADR), scbcIER2_p);
    assign wr_imr    = WENB && isRegHit(64'(WADR), scbcIMR_p);
    assign seq_start = wr_upc && WBEN[0] && WDAT[2];

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        seq_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (seq_start) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_next = WAIT_CLK;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            WAIT_CLK: begin
                if (clk_sync) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next  = IDLE;
                    seq_timeout = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Edge-mode bits (and the timeout bit) are sticky with W1C, where a new
    // set beats a same-cycle clear; level-mode bits simply mirror the synced input.
    always_comb begin
        set_vec   = 32'(irq_sync & ~irq_prev) | {seq_timeout, 31'd0};
        edge_mask = (imr | 32'h8000_0000) & IRQ_MASK;
        w1c       = wr_isr ? (scRegWr('0, WDAT, WBEN) & scbcISR2_w1c_mask) : '0;
        isr_next  = ((((isr & ~w1c) | set_vec) & edge_mask) | (32'(irq_sync) & ~edge_mask)) & IRQ_MASK;
    end

    always_comb begin
        upc_rd                 = '0;
        upc_rd.ulpi_reset      = ulpi_reset;
        upc_rd.ulpi_power_down = ulpi_pwrdn;
        upc_rd.rst_pulse       = (state != IDLE);
        upc_rd.ulpi_clk_st     = clk_sync;

        rd_val = '0;
        if (isRegHit(64'(RADR), scbcVER_p))       rd_val = scbcVER_init;
        else if (isRegHit(64'(RADR), scbcUPC2_p)) rd_val = upc_rd;
        else if (isRegHit(64'(RADR), scbcISR2_p)) rd_val = isr;
        else if (isRegHit(64'(RADR), scbcIER2_p)) rd_val = ier;
        else if (isRegHit(64'(RADR), scbcIMR_p))  rd_val = imr;
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            ulpi_reset <= scbcUPC2_init[0];
            ulpi_pwrdn <= scbcUPC2_init[1];
            isr        <= scbcISR2_init;
            ier        <= scbcIER2_init;
            imr        <= scbcIMR_init;
            irq_prev   <= '0;
            rdat       <= '0;
            irq_out    <= 1'b0;
        end else begin
            if (wr_upc && WBEN[0]) begin
                ulpi_reset <= WDAT[0];
                ulpi_pwrdn <= WDAT[1];
            end
            if (wr_ier) ier <= scRegWr(ier, WDAT, WBEN) & IRQ_MASK;
            if (wr_imr) imr <= scRegWr(imr, WDAT, WBEN) & SRC_MASK;
            isr      <= isr_next;
            irq_prev <= irq_sync;
            rdat     <= RENB ? rd_val : '0;
            irq_out  <= |(isr & ier);
        end
    end

    assign RDAT         = rdat;
    assign INTERRUPT    = irq_out;
    assign ULPI_RSTB    = ~(ulpi_reset | (state == PULSE));
    assign ULPI_PWRDWNB = ~ulpi_pwrdn;

endmodule
